// File: rtl/raw12_pkg.sv
// ---------------------------------------------------------------------------
// raw12_pkg
//
// Purpose: shared types, constants and the RAW12 packing helper used by
//          the raw12_byte_packer top and its raw12_serializer sub-module.
//
// Contents:
//   collectState_e - collector FSM states (NEED_A, NEED_B, FULL)
//   LANE0..LANE2   - serializer lane indices (byte position within a pair)
//   PixelWidth     - width of one FIFO pixel word (12)
//   PairWidth      - width of one packed pixel pair (24)
//   raw12Pack()    - packs two 12-bit pixels into RAW12 byte order
// ---------------------------------------------------------------------------
package raw12_pkg;

   localparam int PixelWidth = 12;
   localparam int PairWidth  = 2 * PixelWidth;

   // Collector progress through one pixel pair.
   typedef enum logic [1:0] {
      NEED_A = 2'd0,
      NEED_B = 2'd1,
      FULL   = 2'd2
   } collectState_e;

   // Lane index selects which byte of the packed pair is on the output.
   localparam logic [1:0] LANE0 = 2'd0;
   localparam logic [1:0] LANE1 = 2'd1;
   localparam logic [1:0] LANE2 = 2'd2;

   // RAW12 order: high bits of A, high bits of B, then both low nibbles
   // with B's nibble on top. The result is {byte0, byte1, byte2}.
   function automatic logic [PairWidth-1:0] raw12Pack(
      input logic [PixelWidth-1:0] pixelA,
      input logic [PixelWidth-1:0] pixelB
   );
      return {pixelA[11:4], pixelB[11:4], pixelB[3:0], pixelA[3:0]};
   endfunction

endpackage : raw12_pkg

// File: rtl/raw12_serializer.sv
// ---------------------------------------------------------------------------
// raw12_serializer
//
// Purpose: holds one packed RAW12 pixel pair (3 bytes) and streams it out
//          one byte per accepted transfer over a valid/ready handshake.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   load_i       in   load loadData_i this edge (honoured only with loadReady_o)
//   loadData_i   in   packed pair {byte0, byte1, byte2}
//   loadReady_o  out  hold register empty, or its last byte transfers this edge
//   dout_o       out  current byte (0 while empty)
//   dvalid_o     out  dout_o valid
//   dready_i     in   sink accepts dout_o this edge
//   lastXfer_o   out  byte2 of the held pair transfers this edge
// ---------------------------------------------------------------------------
module raw12_serializer
   import raw12_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 load_i,
   input  logic [PairWidth-1:0] loadData_i,
   output logic                 loadReady_o,
   output logic [7:0]           dout_o,
   output logic                 dvalid_o,
   input  logic                 dready_i,
   output logic                 lastXfer_o
);

   logic [PairWidth-1:0] holdQ, holdD;
   logic [1:0]           laneQ, laneD;
   logic                 validQ, validD;
   logic                 xfer;

   assign xfer        = validQ & dready_i;
   assign lastXfer_o  = xfer & (laneQ == LANE2);
   // Accepting a new pair on the edge that byte2 leaves keeps the stream
   // gap-free when the collector already has the next pair waiting.
   assign loadReady_o = ~validQ | lastXfer_o;
   assign dvalid_o    = validQ;

   // Output byte select; forced to zero while empty so the idle bus is quiet.
   always_comb begin
      dout_o = 8'h00;
      if (validQ) begin
         case (laneQ)
            LANE0:   dout_o = holdQ[23:16];
            LANE1:   dout_o = holdQ[15:8];
            default: dout_o = holdQ[7:0];
         endcase
      end
   end

   // Next-state: a load takes priority because it can only coincide with
   // the final transfer of the previous pair, which it replaces.
   always_comb begin
      holdD  = holdQ;
      laneD  = laneQ;
      validD = validQ;
      if (load_i && loadReady_o) begin
         holdD  = loadData_i;
         laneD  = LANE0;
         validD = 1'b1;
      end else if (xfer) begin
         if (laneQ == LANE2) begin
            laneD  = LANE0;
            validD = 1'b0;
         end else begin
            laneD = laneQ + 2'd1;
         end
      end
   end

   // Hold register, lane index and valid flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         holdQ  <= '0;
         laneQ  <= LANE0;
         validQ <= 1'b0;
      end else begin
         holdQ  <= holdD;
         laneQ  <= laneD;
         validQ <= validD;
      end
   end

endmodule : raw12_serializer

// File: rtl/raw12_byte_packer.sv
// ---------------------------------------------------------------------------
// raw12_byte_packer
//
// Purpose: read-side consumer of a 12-bit FWFT FIFO. Pops pixel words in
//          pairs, packs each pair into three RAW12 bytes and streams them
//          to a byte sink. A flush pads a dangling odd word with zero.
//
// Parameters:
//   Width       FIFO word width, must be 12
//   CountWidth  width of the emitted-pair counter
//
// Ports:
//   rclk        in   read-domain clock, rising edge
//   rrst_       in   asynchronous active-low reset
//   r           out  pop request; a word is consumed when r & !rempty
//   rd          in   FIFO head word, valid while !rempty
//   rempty      in   FIFO empty
//   dout        out  output byte
//   dvalid      out  dout valid
//   dready      in   sink accepts dout
//   flush       in   single-cycle request to complete a pending odd word
//   flushDone   out  one-cycle pulse once a flush has fully drained
//   pairCount   out  pairs fully emitted, wraps
// ---------------------------------------------------------------------------
module raw12_byte_packer
   import raw12_pkg::*;
#(
   parameter int Width      = 12,
   parameter int CountWidth = 16
) (
   input  logic                  rclk,
   input  logic                  rrst_,
   output logic                  r,
   input  logic [Width-1:0]      rd,
   input  logic                  rempty,
   output logic [7:0]            dout,
   output logic                  dvalid,
   input  logic                  dready,
   input  logic                  flush,
   output logic                  flushDone,
   output logic [CountWidth-1:0] pairCount
);

   generate
      if (Width != PixelWidth) begin : gWidthCheck
         $error("raw12_byte_packer: Width must be 12");
      end
   endgenerate

   collectState_e        stateQ, stateD;
   logic [Width-1:0]     pixelAQ, pixelAD;
   logic [Width-1:0]     pixelBQ, pixelBD;
   logic                 flushPendQ, flushPendD;
   logic                 flushDoneQ, flushDoneD;
   logic [CountWidth-1:0] pairCountQ, pairCountD;

   logic pop;
   logic pendEff;
   logic idleDone;
   logic serLoad;
   logic serLoadReady;
   logic serLastXfer;

   // Pop request follows the collector state; gating with the reset input
   // keeps the FIFO untouched while reset is held.
   assign r   = rrst_ & (stateQ != FULL);
   assign pop = r & ~rempty;

   // A flush arriving this cycle acts immediately, so an idle flush
   // completes one cycle later and a lone A is padded without extra delay.
   assign pendEff  = flushPendQ | flush;
   assign idleDone = (stateQ == NEED_A) & ~dvalid & pendEff;

   // Collector next-state, pad substitution, flush flag and pair counter.
   // Padding only happens on an empty FIFO: a real B word always wins.
   always_comb begin
      stateD     = stateQ;
      pixelAD    = pixelAQ;
      pixelBD    = pixelBQ;
      serLoad    = 1'b0;
      flushPendD = idleDone ? 1'b0 : pendEff;
      flushDoneD = idleDone;
      pairCountD = pairCountQ + CountWidth'(serLastXfer);
      case (stateQ)
         NEED_A: begin
            if (pop) begin
               pixelAD = rd;
               stateD  = NEED_B;
            end
         end
         NEED_B: begin
            if (pop) begin
               pixelBD = rd;
               stateD  = FULL;
            end else if (rempty && pendEff) begin
               pixelBD = '0;
               stateD  = FULL;
            end
         end
         FULL: begin
            if (serLoadReady) begin
               serLoad = 1'b1;
               stateD  = NEED_A;
            end
         end
         default: stateD = NEED_A;
      endcase
   end

   // Collector, flush and counter registers.
   always_ff @(posedge rclk or negedge rrst_) begin
      if (!rrst_) begin
         stateQ     <= NEED_A;
         pixelAQ    <= '0;
         pixelBQ    <= '0;
         flushPendQ <= 1'b0;
         flushDoneQ <= 1'b0;
         pairCountQ <= '0;
      end else begin
         stateQ     <= stateD;
         pixelAQ    <= pixelAD;
         pixelBQ    <= pixelBD;
         flushPendQ <= flushPendD;
         flushDoneQ <= flushDoneD;
         pairCountQ <= pairCountD;
      end
   end

   assign flushDone = flushDoneQ;
   assign pairCount = pairCountQ;

   raw12_serializer uSerializer (
      .clk_i       (rclk),
      .rst_ni      (rrst_),
      .load_i      (serLoad),
      .loadData_i  (raw12Pack(pixelAQ, pixelBQ)),
      .loadReady_o (serLoadReady),
      .dout_o      (dout),
      .dvalid_o    (dvalid),
      .dready_i    (dready),
      .lastXfer_o  (serLastXfer)
   );

endmodule : raw12_byte_packer
